// File: rtl/axi_burst_rd.sv
// AXI4 read burst engine: splits one (address, beat count) command into INCR
// bursts bounded by MAX_BURST and 4 KB pages, forwarding read data zero-latency.
module axi_burst_rd #(
  parameter int ADDR_W    = 30,
  parameter int DATA_W    = 256,
  parameter int LEN_W     = 16,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              done,
  output logic              error,
  output logic              m_axi_arid,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arlock,
  output logic [3:0]        m_axi_arcache,
  output logic [2:0]        m_axi_arprot,
  output logic [3:0]        m_axi_arqos,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFFS  = $clog2(BYTES);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [LEN_W-1:0]  rem_q;
  logic [8:0]        blen_q;
  logic [8:0]        beat_q;
  logic [7:0]        arlen_q;
  logic              done_q;
  logic              error_q;

  logic [ADDR_W-1:0] alignedAddr_d;
  logic [ADDR_W-1:0] advAddr_d;
  logic [LEN_W-1:0]  remNext_d;
  logic [8:0]        blenNext_d;
  logic              rxFire;
  logic              lastBeat;

  // Beats allowed in a burst starting at page offset 'off' with 'r' beats left.
  function automatic logic [8:0] calcBlen(input logic [11:0] off, input logic [LEN_W-1:0] r);
    int unsigned toBound;
    int unsigned b;
    toBound = (32'd4096 - 32'(off)) >> OFFS;
    b = 32'(MAX_BURST);
    if (toBound < b) b = toBound;
    if (32'(r) < b) b = 32'(r);
    return 9'(b);
  endfunction

  always_comb begin
    alignedAddr_d = cmd_addr & ~ADDR_W'(BYTES - 1);
    advAddr_d     = addr_q + (ADDR_W'(blen_q) << OFFS);
    remNext_d     = rem_q - LEN_W'(1);
    if (state_q == IDLE) blenNext_d = calcBlen(alignedAddr_d[11:0], cmd_len);
    else                 blenNext_d = calcBlen(advAddr_d[11:0], remNext_d);
    rxFire   = (state_q == DATA) && m_axi_rvalid && out_ready;
    lastBeat = (beat_q == blen_q - 9'd1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      araddr_q <= '0;
      rem_q    <= '0;
      blen_q   <= '0;
      beat_q   <= '0;
      arlen_q  <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            addr_q  <= alignedAddr_d;
            rem_q   <= cmd_len;
            error_q <= 1'b0;
            if (cmd_len == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q  <= ADDR;
              blen_q   <= blenNext_d;
              araddr_q <= alignedAddr_d;
              arlen_q  <= 8'(blenNext_d - 9'd1);
            end
          end
        end
        ADDR: begin
          if (m_axi_arready) begin
            state_q <= DATA;
            beat_q  <= '0;
          end
        end
        DATA: begin
          if (rxFire) begin
            beat_q <= beat_q + 9'd1;
            rem_q  <= remNext_d;
            // Bad response or rlast out of place is flagged; termination stays counter-based.
            if ((m_axi_rresp != 2'b00) || (m_axi_rlast != lastBeat)) error_q <= 1'b1;
            if (lastBeat) begin
              addr_q <= advAddr_d;
              if (remNext_d == '0) begin
                done_q  <= 1'b1;
                state_q <= IDLE;
              end else begin
                state_q  <= ADDR;
                blen_q   <= blenNext_d;
                araddr_q <= advAddr_d;
                arlen_q  <= 8'(blenNext_d - 9'd1);
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready     = rst && (state_q == IDLE);
  assign done          = done_q;
  assign error         = error_q;
  assign out_valid     = (state_q == DATA) && m_axi_rvalid;
  assign m_axi_rready  = (state_q == DATA) && out_ready;
  assign out_data      = m_axi_rdata;
  assign m_axi_arvalid = (state_q == ADDR);
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arid    = 1'b0;
  assign m_axi_arsize  = 3'(OFFS);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arqos   = 4'b0000;

endmodule

// File: tb/tb_axi_burst_rd.sv
// Directed bench for axi_burst_rd with a simple in-bench AXI read slave whose
// data is a fixed function of the beat address.
module tb_axi_burst_rd;

  logic         clk;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [29:0]  cmd_addr;
  logic [15:0]  cmd_len;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_data;
  logic         done;
  logic         error;
  logic         m_axi_arid;
  logic [29:0]  m_axi_araddr;
  logic [7:0]   m_axi_arlen;
  logic [2:0]   m_axi_arsize;
  logic [1:0]   m_axi_arburst;
  logic         m_axi_arlock;
  logic [3:0]   m_axi_arcache;
  logic [2:0]   m_axi_arprot;
  logic [3:0]   m_axi_arqos;
  logic         m_axi_arvalid;
  logic         m_axi_arready;
  logic [255:0] m_axi_rdata;
  logic [1:0]   m_axi_rresp;
  logic         m_axi_rlast;
  logic         m_axi_rvalid;
  logic         m_axi_rready;

  axi_burst_rd dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .done(done), .error(error),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passCount = 0;
  int totalCount = 0;
  int doneCnt = 0;
  int rreadyBad = 0;
  int errBeat = -1;
  bit earlyLast = 1'b0;

  logic [255:0] outQ[$];
  logic [40:0]  arQ[$];
  logic [40:0]  expAr[$];

  logic        c1Arvalid;
  logic        c1Error;
  logic        c1Done;
  logic [29:0] c1Araddr;
  logic [7:0]  c1Arlen;
  logic        readyAtDone;

  logic        sActive;
  logic [29:0] sAddr;
  logic [7:0]  sLen;
  logic [8:0]  sBeat;

  function automatic logic [255:0] pat(input logic [29:0] a);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = {2'(k), a} ^ 32'hC3A5_0000;
    return r;
  endfunction

  // Slave: accepts one AR at a time, returns arlen+1 beats with rvalid held high.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sActive <= 1'b0;
      sAddr   <= '0;
      sLen    <= '0;
      sBeat   <= '0;
    end else if (!sActive && m_axi_arvalid && m_axi_arready) begin
      sActive <= 1'b1;
      sAddr   <= m_axi_araddr;
      sLen    <= m_axi_arlen;
      sBeat   <= '0;
    end else if (sActive && m_axi_rvalid && m_axi_rready) begin
      sBeat <= sBeat + 9'd1;
      if (sBeat == {1'b0, sLen}) sActive <= 1'b0;
    end
  end

  assign m_axi_arready = !sActive;
  assign m_axi_rvalid  = sActive;
  assign m_axi_rdata   = pat(sAddr + 30'({sBeat, 5'b00000}));
  assign m_axi_rlast   = earlyLast ? (sBeat == 9'd1) : (sBeat == {1'b0, sLen});
  assign m_axi_rresp   = (errBeat >= 0 && sBeat == 9'(errBeat)) ? 2'b10 : 2'b00;

  always @(posedge clk) begin
    if (m_axi_arvalid && m_axi_arready) arQ.push_back({m_axi_araddr, m_axi_arlen, m_axi_arsize});
    if (out_valid && out_ready) outQ.push_back(out_data);
    if (done) doneCnt++;
    if (m_axi_rvalid && (m_axi_rready !== out_ready)) rreadyBad++;
  end

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issues one command, then waits (bounded) for done; returns the done-pulse count.
  task automatic applyStimulus(input logic [29:0] addr, input logic [15:0] len,
                               input bit randReady, output int doneSeen);
    outQ.delete();
    arQ.delete();
    doneCnt = 0;
    readyAtDone = 1'b0;
    @(negedge clk);
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    c1Arvalid = m_axi_arvalid;
    c1Araddr  = m_axi_araddr;
    c1Arlen   = m_axi_arlen;
    c1Error   = error;
    c1Done    = done;
    if (done) readyAtDone = cmd_ready;
    for (int c = 0; c < 4000 && doneCnt == 0; c++) begin
      if (randReady) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (done) readyAtDone = cmd_ready;
    end
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    doneSeen = doneCnt;
  endtask

  task automatic checkData(input string tag, input logic [29:0] base, input int len);
    checkOutput({tag, "_beats"}, 256'(outQ.size()), 256'(len));
    for (int i = 0; i < len && i < outQ.size(); i++)
      checkOutput({tag, "_data"}, outQ[i], pat(base + 30'(i * 32)));
  endtask

  task automatic checkArs(input string tag);
    checkOutput({tag, "_arcount"}, 256'(arQ.size()), 256'(expAr.size()));
    for (int i = 0; i < expAr.size() && i < arQ.size(); i++)
      checkOutput({tag, "_ar"}, 256'(arQ[i]), 256'(expAr[i]));
  endtask

  initial begin
    int ds;
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    out_ready = 1'b1;
    #12;
    checkOutput("rst_cmd_ready", cmd_ready, 0);
    checkOutput("rst_outputs",
                {m_axi_arvalid, m_axi_rready, out_valid, done, error, m_axi_araddr, m_axi_arlen}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("idle_cmd_ready", cmd_ready, 1);

    // Single 4-beat burst; cmd_addr low bits must be ignored.
    applyStimulus(30'h1007, 16'd4, 1'b0, ds);
    checkOutput("single_arvalid_c1", c1Arvalid, 1);
    checkOutput("single_ar_c1", {c1Araddr, c1Arlen}, {30'h1000, 8'd3});
    checkOutput("single_consts",
                {m_axi_arid, m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos},
                {1'b0, 3'd5, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0});
    expAr = '{{30'h1000, 8'd3, 3'd5}};
    checkArs("single");
    checkData("single", 30'h1000, 4);
    checkOutput("single_done", 256'(ds), 1);
    checkOutput("single_ready_at_done", readyAtDone, 1);
    checkOutput("single_error", error, 0);

    applyStimulus(30'h0, 16'd40, 1'b0, ds);
    expAr = '{{30'h0, 8'd15, 3'd5}, {30'h200, 8'd15, 3'd5}, {30'h400, 8'd7, 3'd5}};
    checkArs("split");
    checkData("split", 30'h0, 40);
    checkOutput("split_done", 256'(ds), 1);

    applyStimulus(30'hFC0, 16'd8, 1'b0, ds);
    expAr = '{{30'hFC0, 8'd1, 3'd5}, {30'h1000, 8'd5, 3'd5}};
    checkArs("page");
    checkData("page", 30'hFC0, 8);
    checkOutput("page_done", 256'(ds), 1);

    rreadyBad = 0;
    applyStimulus(30'h4000, 16'd16, 1'b1, ds);
    checkData("bp", 30'h4000, 16);
    checkOutput("bp_rready_mirror", 256'(rreadyBad), 0);
    checkOutput("bp_done", 256'(ds), 1);

    applyStimulus(30'h500, 16'd0, 1'b0, ds);
    checkOutput("zero_done_c1", c1Done, 1);
    checkOutput("zero_arvalid_c1", c1Arvalid, 0);
    checkOutput("zero_ready_at_done", readyAtDone, 1);
    checkOutput("zero_ar_count", 256'(arQ.size()), 0);
    checkOutput("zero_done_count", 256'(ds), 1);

    errBeat = 2;
    applyStimulus(30'h2000, 16'd4, 1'b0, ds);
    errBeat = -1;
    checkOutput("rresp_c1_error", c1Error, 0);
    checkData("rresp", 30'h2000, 4);
    checkOutput("rresp_error", error, 1);
    repeat (5) @(negedge clk);
    checkOutput("rresp_error_held", error, 1);

    earlyLast = 1'b1;
    applyStimulus(30'h3000, 16'd4, 1'b0, ds);
    earlyLast = 1'b0;
    checkOutput("rlast_c1_error_cleared", c1Error, 0);
    checkData("rlast", 30'h3000, 4);
    checkOutput("rlast_error", error, 1);
    checkOutput("rlast_done", 256'(ds), 1);

    // Reset dropped while the engine is streaming a 32-beat command.
    outQ.delete();
    @(negedge clk);
    cmd_addr  = 30'h8000;
    cmd_len   = 16'd32;
    cmd_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 0; c < 200 && outQ.size() < 5; c++) @(negedge clk);
    checkOutput("rstmid_in_data", out_valid, 1);
    #2 rst = 1'b0;
    #1;
    checkOutput("rstmid_cmd_ready", cmd_ready, 0);
    checkOutput("rstmid_outputs",
                {m_axi_arvalid, m_axi_rready, out_valid, done, error, m_axi_araddr, m_axi_arlen}, 0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(30'h2000, 16'd2, 1'b0, ds);
    expAr = '{{30'h2000, 8'd1, 3'd5}};
    checkArs("after_rst");
    checkData("after_rst", 30'h2000, 2);
    checkOutput("after_rst_done", 256'(ds), 1);
    checkOutput("after_rst_error", error, 0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/axi_burst_rd.md
# axi_burst_rd

AXI4 read burst engine sitting directly upstream of the DDR memory (MIG or `axi_ram` model in simulation) on the `m_axi_ar*`/`m_axi_r*` channels. Accepts a single command (start address, beat count) from the system side, splits it into INCR bursts that respect a maximum burst length and the AXI 4 KB boundary, and streams returned read data to the consumer over a valid/ready interface. Has one burst outstanding at a time, and reports completion and response errors.

## Interface
- `ADDR_W`, 30: DDR byte address width (matches `DDR_ADDR_W`).
- `DATA_W`, 256: AXI data width (matches `MIG_BUS_W`). Power of two, at least 32.
- `LEN_W`, 16: width of the command beat count.
- `MAX_BURST`, 16: maximum beats per burst. Power of two, 1..256.

- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_addr`  in  ADDR_W  start byte address. The low log2(DATA_W/8) bits are ignored and forced to 0.
- `cmd_len`  in  LEN_W  number of DATA_W beats to read.
- `out_valid`  out  1  read beat available.
- `out_ready`  in  1  consumer accepts the beat.
- `out_data`  out  DATA_W  read beat.
- `done`  out  1  one-cycle pulse when the command completes.
- `error`  out  1  sticky error flag; cleared when the next command is accepted.
- `m_axi_arid`  out  1  constant 0.
- `m_axi_araddr`  out  ADDR_W  burst start address.
- `m_axi_arlen`  out  8  beats − 1.
- `m_axi_arsize`  out  3  constant log2(DATA_W/8).
- `m_axi_arburst`  out  2  constant 2'b01 (INCR).
- `m_axi_arlock`  out  1  constant 0.
- `m_axi_arcache`  out  4  constant 4'b0011.
- `m_axi_arprot`  out  3  constant 0.
- `m_axi_arqos`  out  4  constant 0.
- `m_axi_arvalid`  out  1  address valid.
- `m_axi_arready`  in  1  address accepted.
- `m_axi_rdata`  in  DATA_W  read data.
- `m_axi_rresp`  in  2  read response.
- `m_axi_rlast`  in  1  last beat of the burst.
- `m_axi_rvalid`  in  1  read data valid.
- `m_axi_rready`  out  1  read data ready.

## Operation
- The FSM has three states: IDLE, ADDR and DATA.
- **IDLE.** `cmd_ready`=1.
  - On `cmd_valid`, latch the address (aligned) and `cmd_len` into `rem`, and clear `error`.
  - If `cmd_len`=0, pulse `done` on the next cycle and stay in IDLE.
  - Otherwise go to ADDR.
- **ADDR.** `m_axi_arvalid`=1, with `araddr`/`arlen` held stable until `arready`.
  - Burst length `blen` = min(`rem`, `MAX_BURST`, beats to the next 4 KB boundary).
  - Beats to the boundary = (4096 − addr[11:0]) / (DATA_W/8).
  - `blen` is computed when entering ADDR and registered.
  - On `arvalid`&`arready`, go to DATA and set the beat counter to 0.
- **DATA.** Pass-through between the AXI read channel and the output:
  - `out_valid` = `m_axi_rvalid`.
  - `m_axi_rready` = `out_ready`.
  - `out_data` = `m_axi_rdata`.
- Each handshake (`rvalid`&`rready`):
  - increments the beat counter and decrements `rem`;
  - sets `error` if `rresp`≠0 (SLVERR and DECERR are treated alike). Data is still forwarded.
- **End of burst.** A burst ends on the handshake where the beat counter equals `blen`−1.
  - If `rlast` does not match that beat (early or missing), set `error`. Burst termination stays counter-based.
  - Address advances by `blen`·(DATA_W/8).
  - If `rem` is 0 after the decrement, pulse `done` and go to IDLE; otherwise go to ADDR.
- Outside DATA, `out_valid`=0 and `m_axi_rready`=0.
- Address arithmetic is modulo 2^ADDR_W; wrap-around at the top of the address space is not flagged.

## Timing
- Reset values: `cmd_ready`=0 during reset, then 1 in IDLE. All other outputs are 0: `arvalid`, `rready`, `out_valid`, `done`, `error`, `araddr`, `arlen`.
- Command accepted at cycle 0 → `arvalid` asserts in cycle 1.
- `arready` at cycle n → first `rready` possible in cycle n+1.
- Last beat handshake at cycle m:
  - `done`=1 in cycle m+1, with `cmd_ready`=1 in the same cycle.
  - Or, if data remains, `arvalid`=1 in cycle m+1.
- Data path has zero latency, with combinational `rvalid`→`out_valid` and `out_ready`→`rready`. Back-pressure therefore stalls AXI directly.
- `arvalid` is never deasserted before `arready` (AXI rule).
- Reset asserted mid-burst returns the block to IDLE immediately, with all outputs at their reset values. The memory model is reset together with this block.

## Test plan
- **Single burst.** Command `addr`=0x1000, `len`=4, `DATA_W`=256, slave `arready` immediate → one AR with `araddr`=0x1000, `arlen`=3, `arsize`=5. Four beats appear on `out_data` in order, `done` pulses once, `error`=0.
- **Split at MAX_BURST.** Command `addr`=0, `len`=40 → ARs with `arlen` 15, 15, 7 at `araddr` 0x0, 0x200, 0x400. 40 beats out, then `done`.
- **4 KB boundary.** Command `addr`=0xFC0, `len`=8 → AR (0xFC0, `arlen`=1) then AR (0x1000, `arlen`=5). No burst crosses 0x1000.
- **Back-pressure and zero length.**
  - Toggle `out_ready` randomly 50% on `len`=16 → data order intact, `rready` mirrors `out_ready`, no beat lost.
  - `len`=0 → `done` at cycle 1, no AR issued.
- **Error cases.**
  - `rresp`=2'b10 on beat 2 of `len`=4 → all 4 beats delivered, `error`=1 after the beat and held until the next command is accepted.
  - `rlast` asserted on beat 1 of a 4-beat burst → `error`=1.
- **Reset mid-burst.** Drop `rst` during the DATA state of `len`=32 → outputs at reset values within the same cycle. A new command of `len`=2 after release completes normally.
